// File: rtl/dice_match_ctrl.sv
// dice_match_ctrl: match controller downstream of the dice FSM.
// Starts rounds, scores RED/BLUE wins and reports the match winner.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   play       level; starts a new match from IDLE or DONE
//   abort      synchronous return to IDLE from any state
//   color      dice colour (00 NONE, 01 RED, 10 BLUE, 11 read as NONE)
//   dice_start one-cycle start pulse to the dice block (KICK only)
//   red_score  RED round wins this match
//   blue_score BLUE round wins this match
//   round_cnt  rounds completed this match
//   winner     00 none/tie, 01 RED, 10 BLUE; valid while done=1
//   done       match result valid
module dice_match_ctrl #(
  parameter int WIN_TARGET = 3,
  parameter int MAX_ROUNDS = 15,
  parameter int ROUND_WIN  = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       play,
  input  logic       abort,
  input  logic [1:0] color,
  output logic       dice_start,
  output logic [3:0] red_score,
  output logic [3:0] blue_score,
  output logic [3:0] round_cnt,
  output logic [1:0] winner,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KICK,
    S_ROLL,
    S_EVAL,
    S_DONE
  } state_t;

  localparam logic [3:0] WT = 4'(WIN_TARGET);
  localparam logic [3:0] MR = 4'(MAX_ROUNDS);
  localparam logic [3:0] RL = 4'(ROUND_WIN - 1);

  localparam logic [1:0] C_NONE = 2'b00;
  localparam logic [1:0] C_RED  = 2'b01;
  localparam logic [1:0] C_BLUE = 2'b10;

  state_t     state;
  logic [1:0] cap;
  logic [3:0] win_cnt;

  logic       red_hit;
  logic       blue_hit;
  logic       col_ok;
  logic [3:0] red_nx;
  logic [3:0] blue_nx;
  logic [3:0] rnd_nx;
  logic [1:0] lead;

  // Values the EVAL cycle commits; the end-of-match
  // decision is made on these, not on the old scores.
  always_comb begin
    red_hit  = (cap == C_RED);
    blue_hit = (cap == C_BLUE);
    col_ok   = (color == C_RED) || (color == C_BLUE);
    red_nx   = red_score + {3'b000, red_hit};
    blue_nx  = blue_score + {3'b000, blue_hit};
    rnd_nx   = round_cnt + 4'd1;
    lead     = C_NONE;
    unique case (1'b1)
      (red_nx > blue_nx): lead = C_RED;
      (blue_nx > red_nx): lead = C_BLUE;
      default:            lead = C_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      dice_start <= 1'b0;
      red_score  <= 4'd0;
      blue_score <= 4'd0;
      round_cnt  <= 4'd0;
      winner     <= C_NONE;
      done       <= 1'b0;
      cap        <= C_NONE;
      win_cnt    <= 4'd0;
    end else if (abort) begin
      state      <= S_IDLE;
      dice_start <= 1'b0;
      red_score  <= 4'd0;
      blue_score <= 4'd0;
      round_cnt  <= 4'd0;
      winner     <= C_NONE;
      done       <= 1'b0;
      cap        <= C_NONE;
      win_cnt    <= 4'd0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (play) begin
            state      <= S_KICK;
            dice_start <= 1'b1;
            done       <= 1'b0;
            red_score  <= 4'd0;
            blue_score <= 4'd0;
            round_cnt  <= 4'd0;
            winner     <= C_NONE;
          end
        end
        S_KICK: begin
          state      <= S_ROLL;
          dice_start <= 1'b0;
          cap        <= C_NONE;
          win_cnt    <= 4'd0;
        end
        S_ROLL: begin
          // Only the first RED/BLUE of the window counts.
          if (cap == C_NONE && col_ok) begin
            cap <= color;
          end
          if (win_cnt == RL) begin
            state <= S_EVAL;
          end else begin
            win_cnt <= win_cnt + 4'd1;
          end
        end
        S_EVAL: begin
          round_cnt  <= rnd_nx;
          red_score  <= red_nx;
          blue_score <= blue_nx;
          unique case (1'b1)
            (red_nx == WT): begin
              state  <= S_DONE;
              done   <= 1'b1;
              winner <= C_RED;
            end
            (blue_nx == WT): begin
              state  <= S_DONE;
              done   <= 1'b1;
              winner <= C_BLUE;
            end
            (rnd_nx == MR): begin
              state  <= S_DONE;
              done   <= 1'b1;
              winner <= lead;
            end
            default: begin
              state      <= S_KICK;
              dice_start <= 1'b1;
            end
          endcase
        end
        default: begin
          state      <= S_IDLE;
          dice_start <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dice_match_ctrl.md
Name: dice_match_ctrl

Overview:
- Match controller that sits directly downstream of the dice FSM.
- Issues one start pulse per round to the dice block, then watches the dice 2-bit colour output for that round's result (RED=01, BLUE=10, NONE=00).
- Keeps per-colour scores and ends the match when a colour reaches the win target or the round budget runs out.
- Presents the final winner to the board-level display/LED logic.

Parameters:
- WIN_TARGET, 3: wins needed to end the match early; legal range 1..15.
- MAX_ROUNDS, 15: round budget per match; legal range 1..15.
- ROUND_WIN, 6: number of ROLL cycles in which the dice colour is sampled after each start pulse; legal range 5..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- play  input  1  level; sampled in IDLE or DONE to begin a new match.
- abort  input  1  synchronous; returns to IDLE from any state.
- color  input  2  dice colour output (00 NONE, 01 RED, 10 BLUE, 11 illegal).
- dice_start  output  1  one-cycle start pulse to the dice block.
- red_score  output  4  RED round wins in the current match.
- blue_score  output  4  BLUE round wins in the current match.
- round_cnt  output  4  rounds completed in the current match.
- winner  output  2  00 none/tie, 01 RED, 10 BLUE; valid while done=1.
- done  output  1  high in DONE; match result valid.

Behaviour:
- Reset and registers: clk and rst as stated above. All outputs are registered. On rst low: state=IDLE; dice_start=0, red_score=0, blue_score=0, round_cnt=0, winner=00, done=0; internal capture register and window counter cleared.
- Reset mid-match: same as above, takes effect immediately; no partial round is scored.
- States: IDLE, KICK, ROLL, EVAL, DONE.
- IDLE: play=1 → KICK; on the same edge, scores, round_cnt and winner are cleared.
- KICK (exactly 1 cycle): dice_start=1, capture register cleared, window counter cleared → ROLL.
- dice_start is high only while in KICK.
- ROLL (exactly ROUND_WIN cycles): sample color every cycle.
  - The first sample equal to 01 or 10 is latched into the capture register.
  - Later non-zero samples in the same window are ignored.
  - 11 is treated as NONE.
  - When the counter reaches ROUND_WIN-1 → EVAL.
- EVAL (1 cycle):
  - round_cnt+1.
  - If capture=01, red_score+1; if capture=10, blue_score+1; if capture=00, no score change.
  - Next-state decision uses the updated values:
    - a score equals WIN_TARGET → DONE, winner = that colour;
    - else round_cnt equals MAX_ROUNDS → DONE, winner = higher score, or 00 on a tie;
    - else → KICK.
- Round period: ROUND_WIN+2 cycles (8 at defaults).
- DONE: done=1; scores, round_cnt and winner are held. play=1 → KICK with a fresh match; on the same edge done drops and scores, round_cnt and winner are cleared.
- play: ignored in KICK, ROLL and EVAL; it is level-sensitive, so play held high after DONE immediately restarts.
- abort: has priority over play and all transitions. On the next edge: state=IDLE, done=0, dice_start=0; scores and round_cnt cleared, winner=00.
- color outside ROLL: ignored, including any pulse arriving in KICK or EVAL.
- Widths: scores and round_cnt are 4-bit and can never exceed 15 given the parameter limits, so no wrap handling is required.

Test Plan:
- Reset, play held at 0 → all outputs 0, dice_start never pulses over 100 cycles.
- play pulse; color model returns RED 5 cycles after each dice_start → 3 dice_start pulses 8 cycles apart; after 3rd EVAL red_score=3, blue_score=0, round_cnt=3, winner=01, done=1.
- Color sequence BLUE, NONE, RED, BLUE, BLUE → done after round 5; blue_score=3, red_score=1, round_cnt=5, winner=10.
- MAX_ROUNDS=4, WIN_TARGET=3; sequence RED, BLUE, RED, BLUE → done after round 4; winner=00, scores 2/2.
- Within one window drive RED then BLUE, plus 11 and a RED pulse during KICK → only the first RED is scored (red_score+1, blue unchanged).
- abort in ROLL of round 2, and a separate rst low in EVAL → IDLE, all counters 0, done=0; next play starts with round_cnt=0.
